// File: rtl/mdio_pkg.sv
// Shared types and constants for the Clause 22 MDIO management controller.
package mdio_pkg;

    typedef enum logic [2:0] {
        S_RST_HOLD = 3'd0,
        S_RST_WAIT = 3'd1,
        S_IDLE     = 3'd2,
        S_SHIFT    = 3'd3,
        S_GAP      = 3'd4,
        S_RESP     = 3'd5
    } state_t;

    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_READ   = 2'b10;
    localparam logic [1:0] ST        = 2'b01;

    localparam logic [5:0] PRE_END   = 6'd31;
    localparam logic [5:0] TA_POS    = 6'd46;
    localparam logic [5:0] DATA_POS  = 6'd48;
    localparam int         FRAME_LEN = 64;

    // Full 64-bit frame, bit 0 of the frame in the MSB. For reads the TA and
    // data fields are never driven (oe low), so they are filled with idle ones.
    function automatic logic [FRAME_LEN-1:0] build_frame(
        input logic        wr,
        input logic [4:0]  phy,
        input logic [4:0]  regad,
        input logic [15:0] wdata
    );
        return {{(int'(PRE_END) + 1){1'b1}},
                ST,
                wr ? OP_WRITE : OP_READ,
                phy,
                regad,
                wr ? 2'b10 : 2'b11,
                wr ? wdata : 16'hFFFF};
    endfunction

endpackage

// File: rtl/mdio_mdc_gen.sv
// MDC generator: one bit period is MDC_DIV cycles low followed by MDC_DIV
// cycles high. Held in its idle phase (MDC low, counter reloaded) when disabled.
module mdio_mdc_gen #(
    parameter int MDC_DIV = 25
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_mdc,
    output logic o_bit_start,
    output logic o_rise
);

    localparam int CW = $clog2(MDC_DIV);

    logic [CW-1:0] r_cnt;
    logic          r_phase;
    logic          w_tc;

    assign w_tc = (r_cnt == '0);

    // Half-period down-counter; the phase toggles at each terminal count.
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_en) begin
            r_cnt   <= CW'(MDC_DIV - 1);
            r_phase <= 1'b0;
        end else if (w_tc) begin
            r_cnt   <= CW'(MDC_DIV - 1);
            r_phase <= ~r_phase;
        end else begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // o_bit_start: last cycle of a bit; MDC falls and the next bit begins at
    // the coming edge. o_rise: last low cycle; MDC rises at the coming edge.
    always_comb begin
        o_mdc       = r_phase;
        o_bit_start = i_en && w_tc && r_phase;
        o_rise      = i_en && w_tc && !r_phase;
    end

endmodule

// File: rtl/mdio_phy_ctrl.sv
// GMII PHY management: PHY hardware reset sequencing, then single-register
// Clause 22 read/write frames on MDC/MDIO.
//
// state      | meaning
// -----------+------------------------------------------------------------
// RST_HOLD   | gmii_rstn low, counting RST_HOLD cycles
// RST_WAIT   | gmii_rstn high, PHY settling for RST_WAIT cycles
// IDLE       | req_ready high, waiting for a request
// SHIFT      | 64-bit frame on MDIO, one bit per MDC period
// GAP        | one idle bit period after the frame
// RESP       | rsp_valid high until rsp_ready
module mdio_phy_ctrl
    import mdio_pkg::*;
#(
    parameter int MDC_DIV  = 25,
    parameter int RST_HOLD = 1250000,
    parameter int RST_WAIT = 625000
) (
    input  logic        sys125Clk,
    input  logic        sys125Rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [4:0]  req_phy,
    input  logic [4:0]  req_reg,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        gmii_rstn,
    output logic        mdio_mdc,
    output logic        mdio_mdd_o,
    output logic        mdio_mdd_oe,
    input  logic        mdio_mdd_i
);

    localparam int RST_MAX = (RST_HOLD > RST_WAIT) ? RST_HOLD : RST_WAIT;
    localparam int RCW     = $clog2(RST_MAX + 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [RCW-1:0]         r_cnt;
    logic [5:0]             r_bit;
    logic [FRAME_LEN-1:0]   r_frame;
    logic                   r_write;
    logic                   r_mdi_s1;
    logic                   r_mdi_s2;
    logic [15:0]            r_rdata;
    logic                   r_err;

    logic w_mdc;
    logic w_bit_start;
    logic w_rise;
    logic w_shift;
    logic w_accept;
    logic w_cnt_tc;
    logic w_frame_end;

    assign w_shift     = (r_state == S_SHIFT);
    assign w_accept    = req_valid && (r_state == S_IDLE);
    assign w_cnt_tc    = (r_cnt == '0);
    assign w_frame_end = w_bit_start && (r_bit == 6'(FRAME_LEN - 1));

    mdio_mdc_gen #(.MDC_DIV(MDC_DIV)) u_mdc_gen (
        .i_clk       (sys125Clk),
        .i_rst       (sys125Rst),
        .i_en        (w_shift),
        .o_mdc       (w_mdc),
        .o_bit_start (w_bit_start),
        .o_rise      (w_rise)
    );

    // State register.
    always_ff @(posedge sys125Clk) begin
        if (sys125Rst) r_state <= S_RST_HOLD;
        else           r_state <= w_state_nxt;
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RST_HOLD: if (w_cnt_tc)    w_state_nxt = S_RST_WAIT;
            S_RST_WAIT: if (w_cnt_tc)    w_state_nxt = S_IDLE;
            S_IDLE:     if (req_valid)   w_state_nxt = S_SHIFT;
            S_SHIFT:    if (w_frame_end) w_state_nxt = S_GAP;
            S_GAP:      if (w_cnt_tc)    w_state_nxt = S_RESP;
            S_RESP:     if (rsp_ready)   w_state_nxt = S_IDLE;
            default:                     w_state_nxt = S_RST_HOLD;
        endcase
    end

    // Outputs decoded from state; MDIO value comes from the frame shifter.
    always_comb begin
        gmii_rstn   = (r_state != S_RST_HOLD);
        req_ready   = (r_state == S_IDLE);
        rsp_valid   = (r_state == S_RESP);
        mdio_mdc    = w_mdc;
        mdio_mdd_o  = w_shift ? r_frame[FRAME_LEN-1] : 1'b1;
        mdio_mdd_oe = w_shift && (r_write || (r_bit < TA_POS));
        rsp_rdata   = r_rdata;
        rsp_err     = r_err;
    end

    // Shared down-counter: reset hold, reset wait, and the post-frame gap.
    always_ff @(posedge sys125Clk) begin
        if (sys125Rst) begin
            r_cnt <= RCW'(RST_HOLD - 1);
        end else begin
            case (r_state)
                S_RST_HOLD: r_cnt <= w_cnt_tc ? RCW'(RST_WAIT - 1) : r_cnt - 1'b1;
                S_RST_WAIT,
                S_GAP:      if (!w_cnt_tc) r_cnt <= r_cnt - 1'b1;
                S_SHIFT:    if (w_frame_end) r_cnt <= RCW'(2 * MDC_DIV - 1);
                default:    r_cnt <= r_cnt;
            endcase
        end
    end

    // Frame shifter and bit position; both advance at each MDC falling edge.
    always_ff @(posedge sys125Clk) begin
        if (sys125Rst) begin
            r_frame <= '1;
            r_bit   <= '0;
            r_write <= 1'b0;
        end else if (w_accept) begin
            r_frame <= build_frame(req_write, req_phy, req_reg, req_wdata);
            r_bit   <= '0;
            r_write <= req_write;
        end else if (w_bit_start) begin
            r_frame <= {r_frame[FRAME_LEN-2:0], 1'b1};
            r_bit   <= r_bit + 1'b1;
        end
    end

    // Two-flop synchronizer for the asynchronous MDIO pad input.
    always_ff @(posedge sys125Clk) begin
        if (sys125Rst) begin
            r_mdi_s1 <= 1'b1;
            r_mdi_s2 <= 1'b1;
        end else begin
            r_mdi_s1 <= mdio_mdd_i;
            r_mdi_s2 <= r_mdi_s1;
        end
    end

    // Read capture at MDC rise: second TA bit must be 0, then 16 data bits.
    always_ff @(posedge sys125Clk) begin
        if (sys125Rst || w_accept) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_rise && !r_write) begin
            if (r_bit == TA_POS + 6'd1)
                r_err <= r_mdi_s2;
            else if (r_bit >= DATA_POS)
                r_rdata <= {r_rdata[14:0], r_mdi_s2};
        end
    end

endmodule
